// File: rtl/inst_decode_stage_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU control codes
// and the control bundle produced by the decoder.
package inst_decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    jump;
    logic    branch;
    logic    alusrc;
    logic    memwrite;
    logic    memtoreg;
    logic    regwrite;
    logic    regdst;
    alu_op_e alucontrol;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/inst_decode_stage_ctrl_decoder.sv
// Combinational MIPS main decoder: opcode/funct to control bundle.
// Any undecodable instruction yields illegal=1 with every control low.
module ctrl_decoder
  import inst_decode_stage_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_nop,
  output ctrl_t      o_ctrl
);

  // NOTE: the default assignment first means every path drives o_ctrl, so no latch is inferred.
  always_comb begin
    o_ctrl = '0;
    if (!i_nop) begin
      case (i_op)
        OP_RTYPE: begin
          o_ctrl.regwrite = 1'b1;
          o_ctrl.regdst   = 1'b1;
          case (i_funct)
            FN_ADD:  o_ctrl.alucontrol = ALU_ADD;
            FN_SUB:  o_ctrl.alucontrol = ALU_SUB;
            FN_AND:  o_ctrl.alucontrol = ALU_AND;
            FN_OR:   o_ctrl.alucontrol = ALU_OR;
            FN_SLT:  o_ctrl.alucontrol = ALU_SLT;
            default: begin
              o_ctrl         = '0;
              o_ctrl.illegal = 1'b1;
            end
          endcase
        end
        OP_LW: begin
          o_ctrl.regwrite   = 1'b1;
          o_ctrl.alusrc     = 1'b1;
          o_ctrl.memtoreg   = 1'b1;
          o_ctrl.alucontrol = ALU_ADD;
        end
        OP_SW: begin
          o_ctrl.alusrc     = 1'b1;
          o_ctrl.memwrite   = 1'b1;
          o_ctrl.alucontrol = ALU_ADD;
        end
        OP_BEQ: begin
          o_ctrl.branch     = 1'b1;
          o_ctrl.alucontrol = ALU_SUB;
        end
        OP_ADDI: begin
          o_ctrl.regwrite   = 1'b1;
          o_ctrl.alusrc     = 1'b1;
          o_ctrl.alucontrol = ALU_ADD;
        end
        OP_J:    o_ctrl.jump    = 1'b1;
        default: o_ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// IF/ID pipeline stage: registers the fetched instruction and PC+4, decodes
// it into registered controls/fields, with stall, flush, sticky illegal flag and counter.
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              fetch_valid,
  input  logic [DATA_W-1:0] inst_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic              stall,
  input  logic              flush,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_inst,
  output logic [DATA_W-1:0] id_pc4,
  output logic              jump,
  output logic              branch,
  output logic              alusrc,
  output logic              memwrite,
  output logic              memtoreg,
  output logic              regwrite,
  output logic              regdst,
  output logic [2:0]        alucontrol,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm_ext,
  output logic [DATA_W-1:0] jump_target,
  output logic              illegal,
  output logic              illegal_seen,
  output logic [CNT_W-1:0]  dec_count
);

  ctrl_t             w_ctrl;
  logic              w_nop;
  logic              w_bubble;

  logic              r_valid;
  logic [DATA_W-1:0] r_inst;
  logic [DATA_W-1:0] r_pc4;
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_imm_ext;
  logic [DATA_W-1:0] r_jump_target;
  logic              r_illegal_seen;
  logic [CNT_W-1:0]  r_dec_count;

  assign w_nop = (inst_in == '0);

  ctrl_decoder u_ctrl_decoder (
    .i_op    (inst_in[31:26]),
    .i_funct (inst_in[5:0]),
    .i_nop   (w_nop),
    .o_ctrl  (w_ctrl)
  );

  // Flush always bubbles; an unstalled cycle without a fetch bubbles as well.
  assign w_bubble = flush || (!stall && !fetch_valid);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_valid        <= 1'b0;
      r_inst         <= '0;
      r_pc4          <= '0;
      r_ctrl         <= '0;
      r_imm_ext      <= '0;
      r_jump_target  <= '0;
      r_illegal_seen <= 1'b0;
      r_dec_count    <= '0;
    end else if (w_bubble) begin
      r_valid       <= 1'b0;
      r_inst        <= '0;
      r_pc4         <= '0;
      r_ctrl        <= '0;
      r_imm_ext     <= '0;
      r_jump_target <= '0;
    end else if (!stall) begin
      r_valid        <= 1'b1;
      r_inst         <= inst_in;
      r_pc4          <= pc4_in;
      r_ctrl         <= w_ctrl;
      r_imm_ext      <= {{(DATA_W-16){inst_in[15]}}, inst_in[15:0]};
      r_jump_target  <= {pc4_in[DATA_W-1 -: 4], inst_in[25:0], 2'b00};
      r_illegal_seen <= r_illegal_seen | w_ctrl.illegal;
      r_dec_count    <= r_dec_count + CNT_W'(1);
    end
  end

  assign id_valid     = r_valid;
  assign id_inst      = r_inst;
  assign id_pc4       = r_pc4;
  assign jump         = r_ctrl.jump;
  assign branch       = r_ctrl.branch;
  assign alusrc       = r_ctrl.alusrc;
  assign memwrite     = r_ctrl.memwrite;
  assign memtoreg     = r_ctrl.memtoreg;
  assign regwrite     = r_ctrl.regwrite;
  assign regdst       = r_ctrl.regdst;
  assign alucontrol   = r_ctrl.alucontrol;
  assign illegal      = r_ctrl.illegal;
  assign rs           = r_inst[25:21];
  assign rt           = r_inst[20:16];
  assign rd           = r_inst[15:11];
  assign imm_ext      = r_imm_ext;
  assign jump_target  = r_jump_target;
  assign illegal_seen = r_illegal_seen;
  assign dec_count    = r_dec_count;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed self-checking bench for inst_decode_stage; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_inst_decode_stage;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        fetch_valid;
  logic [31:0] inst_in;
  logic [31:0] pc4_in;
  logic        stall;
  logic        flush;

  logic        id_valid, jump, branch, alusrc, memwrite, memtoreg, regwrite, regdst;
  logic        illegal, illegal_seen;
  logic [31:0] id_inst, id_pc4, imm_ext, jump_target, dec_count;
  logic [2:0]  alucontrol;
  logic [4:0]  rs, rt, rd;

  logic        id_valid_4, jump_4, branch_4, alusrc_4, memwrite_4, memtoreg_4, regwrite_4, regdst_4;
  logic        illegal_4, illegal_seen_4;
  logic [31:0] id_inst_4, id_pc4_4, imm_ext_4, jump_target_4;
  logic [3:0]  dec_count_4;
  logic [2:0]  alucontrol_4;
  logic [4:0]  rs_4, rt_4, rd_4;

  logic [6:0]  ctrl;
  int          n_checks = 0;
  int          n_errors = 0;

  assign ctrl = {jump, branch, alusrc, memwrite, memtoreg, regwrite, regdst};

  always #5 clk = ~clk;

  inst_decode_stage dut (
    .clk(clk), .clr_n(clr_n), .fetch_valid(fetch_valid), .inst_in(inst_in),
    .pc4_in(pc4_in), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc4(id_pc4), .jump(jump), .branch(branch),
    .alusrc(alusrc), .memwrite(memwrite), .memtoreg(memtoreg),
    .regwrite(regwrite), .regdst(regdst), .alucontrol(alucontrol),
    .rs(rs), .rt(rt), .rd(rd), .imm_ext(imm_ext), .jump_target(jump_target),
    .illegal(illegal), .illegal_seen(illegal_seen), .dec_count(dec_count)
  );

  inst_decode_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .fetch_valid(fetch_valid), .inst_in(inst_in),
    .pc4_in(pc4_in), .stall(stall), .flush(flush), .id_valid(id_valid_4),
    .id_inst(id_inst_4), .id_pc4(id_pc4_4), .jump(jump_4), .branch(branch_4),
    .alusrc(alusrc_4), .memwrite(memwrite_4), .memtoreg(memtoreg_4),
    .regwrite(regwrite_4), .regdst(regdst_4), .alucontrol(alucontrol_4),
    .rs(rs_4), .rt(rt_4), .rd(rd_4), .imm_ext(imm_ext_4), .jump_target(jump_target_4),
    .illegal(illegal_4), .illegal_seen(illegal_seen_4), .dec_count(dec_count_4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Outputs change only on the rising edge; sample 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] inst, input logic [31:0] pc4);
    fetch_valid = fv;
    inst_in     = inst;
    pc4_in      = pc4;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(id_valid), 32'd0);
    check({tag, ".inst"}, id_inst, 32'd0);
    check({tag, ".pc4"}, id_pc4, 32'd0);
    check({tag, ".ctrl"}, 32'(ctrl), 32'd0);
    check({tag, ".alu"}, 32'(alucontrol), 32'd0);
    check({tag, ".regs"}, 32'({rs, rt, rd}), 32'd0);
    check({tag, ".imm"}, imm_ext, 32'd0);
    check({tag, ".jt"}, jump_target, 32'd0);
    check({tag, ".illegal"}, 32'({illegal, illegal_seen}), 32'd0);
    check({tag, ".count"}, dec_count, 32'd0);
    check({tag, ".count4"}, 32'(dec_count_4), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [6:0]  ctrl;
    logic [2:0]  alu;
  } vec_t;

  vec_t stream[5];
  vec_t rops[4];

  initial begin
    stream[0] = '{"add", 32'h0022_1820, 7'b0000011, 3'b010};
    stream[1] = '{"lw",  32'h8C23_0004, 7'b0010110, 3'b010};
    stream[2] = '{"sw",  32'hAC23_0008, 7'b0011000, 3'b010};
    stream[3] = '{"beq", 32'h1022_0003, 7'b0100000, 3'b110};
    stream[4] = '{"j",   32'h0800_0010, 7'b1000000, 3'b000};
    rops[0]   = '{"sub", 32'h0022_1822, 7'b0000011, 3'b110};
    rops[1]   = '{"and", 32'h0022_1824, 7'b0000011, 3'b000};
    rops[2]   = '{"or",  32'h0022_1825, 7'b0000011, 3'b001};
    rops[3]   = '{"slt", 32'h0022_182A, 7'b0000011, 3'b111};

    clr_n = 1'b0; fetch_valid = 1'b0; inst_in = '0; pc4_in = '0;
    stall = 1'b0; flush = 1'b0;
    step();
    check_all_zero("por");
    step();
    clr_n = 1'b1;

    // Main instruction stream
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, stream[i].inst, 32'h0040_0004);
      check({stream[i].name, ".valid"}, 32'(id_valid), 32'd1);
      check({stream[i].name, ".ctrl"}, 32'(ctrl), 32'(stream[i].ctrl));
      check({stream[i].name, ".illegal"}, 32'(illegal), 32'd0);
      if (i < 4) check({stream[i].name, ".alu"}, 32'(alucontrol), 32'(stream[i].alu));
      check({stream[i].name, ".count"}, dec_count, 32'(i + 1));
    end
    check("j.jt", jump_target, 32'h0000_0040);
    check("j.inst", id_inst, 32'h0800_0010);
    check("j.pc4", id_pc4, 32'h0040_0004);

    // Stall holds everything
    stall = 1'b1;
    drive(1'b1, 32'h0022_1820, 32'hA000_0010);
    drive(1'b1, 32'h8C23_0004, 32'hA000_0010);
    check("stall.ctrl", 32'(ctrl), 32'h40);
    check("stall.inst", id_inst, 32'h0800_0010);
    check("stall.pc4", id_pc4, 32'h0040_0004);
    check("stall.count", dec_count, 32'd5);
    flush = 1'b1;
    drive(1'b1, 32'h0022_1820, 32'hA000_0010);
    check("flush.valid", 32'(id_valid), 32'd0);
    check("flush.regwrite", 32'(regwrite), 32'd0);
    check("flush.ctrl", 32'(ctrl), 32'd0);
    check("flush.count", dec_count, 32'd5);
    stall = 1'b0; flush = 1'b0;

    // Jump target takes its top nibble from pc4
    drive(1'b1, 32'h0800_0010, 32'hA000_0010);
    check("j2.jt", jump_target, 32'hA000_0040);
    check("j2.count", dec_count, 32'd6);

    // Illegal opcode and illegal funct
    drive(1'b1, 32'hFC00_0000, 32'h0);
    check("ill.valid", 32'(id_valid), 32'd1);
    check("ill.flags", 32'({illegal, illegal_seen}), 32'b11);
    check("ill.ctrl", 32'(ctrl), 32'd0);
    check("ill.alu", 32'(alucontrol), 32'd0);
    check("ill.count", dec_count, 32'd7);
    drive(1'b1, 32'h0022_1821, 32'h0);
    check("illfn.illegal", 32'(illegal), 32'd1);
    drive(1'b1, 32'h0022_1820, 32'h0);
    check("postill.flags", 32'({illegal, illegal_seen}), 32'b01);
    check("postill.ctrl", 32'(ctrl), 32'b0000011);
    check("postill.count", dec_count, 32'd9);

    // NOP is a valid, counted, control-free instruction
    drive(1'b1, 32'h0, 32'h0);
    check("nop.valid", 32'(id_valid), 32'd1);
    check("nop.ctrl", 32'({ctrl, illegal}), 32'd0);
    check("nop.count", dec_count, 32'd10);

    // No fetch: garbage inst must not leak
    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nofetch.valid", 32'(id_valid), 32'd0);
    check("nofetch.ctrl", 32'({ctrl, alucontrol, illegal}), 32'd0);
    check("nofetch.count", dec_count, 32'd10);
    check("nofetch.seen", 32'(illegal_seen), 32'd1);

    // Sign extension
    drive(1'b1, 32'h2001_FFFF, 32'h0);
    check("addi.ctrl", 32'(ctrl), 32'b0010010);
    check("addi.alu", 32'(alucontrol), 32'b010);
    check("addi.imm", imm_ext, 32'hFFFF_FFFF);
    check("addi.fields", 32'({rs, rt}), 32'({5'd0, 5'd1}));
    check("addi.count", dec_count, 32'd11);

    // Remaining R-type ALU ops
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rops[i].inst, 32'h0);
      check({rops[i].name, ".ctrl"}, 32'(ctrl), 32'(rops[i].ctrl));
      check({rops[i].name, ".alu"}, 32'(alucontrol), 32'(rops[i].alu));
      check({rops[i].name, ".rd"}, 32'(rd), 32'd3);
    end
    check("rops.count", dec_count, 32'd15);

    // Asynchronous reset mid-run, between clock edges
    #2;
    stall = 1'b1; flush = 1'b1;
    clr_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    check_all_zero("rst_hold");
    clr_n = 1'b1; stall = 1'b0; flush = 1'b0;

    // Counter wrap on the 4-bit instance: 17 captures -> 1
    for (int i = 0; i < 17; i++) drive(1'b1, 32'h0022_1820, 32'h0);
    check("wrap.count4", 32'(dec_count_4), 32'd1);
    check("wrap.count", dec_count, 32'd17);
    check("wrap.valid4", 32'(id_valid_4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
